// File: rtl/truth_table_checker.sv
// Golden truth-table response checker: compares each (vec, y_obs) row against GOLDEN,
// tracks coverage and unique-row mismatches, and gives a pass/fail verdict once all rows are seen.
// Optional ascending-order tracking is enabled by defining TTC_STRICT_ORDER_EN.
module truth_table_checker #(
    parameter int          N_IN   = 4,
    parameter logic [15:0] GOLDEN = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            vec_valid,
    input  logic [N_IN-1:0] vec,
    input  logic            y_obs,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [4:0]      err_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_vec,
    output logic [15:0]     coverage,
    output logic            seq_err
);

    localparam int unsigned ROWS     = 1 << N_IN;
    localparam logic [15:0] ROW_MASK = 16'((32'd1 << ROWS) - 32'd1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]  state;
    logic        take_vec;
    logic        accept;
    logic        mismatch;
    logic        complete;
    logic [15:0] cov_next;
    logic [4:0]  err_next;
    logic        seq_next;

    assign busy = (state == ST_COLLECT);
    assign done = (state == ST_DONE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        take_vec = (state == ST_COLLECT) && vec_valid && !start;
        accept   = take_vec && !coverage[vec];
        mismatch = accept && (y_obs != GOLDEN[vec]);
        cov_next = coverage;
        if (accept) begin
            cov_next[vec] = 1'b1;
        end
        err_next = mismatch ? err_count + 5'd1 : err_count;
        complete = accept && ((cov_next & ROW_MASK) == ROW_MASK);
    end

`ifdef TTC_STRICT_ORDER_EN
    logic [N_IN-1:0] exp_idx;

    // Duplicates count as arrivals too, so a repeated row is also an ordering violation.
    assign seq_next = seq_err || (take_vec && (vec != exp_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_idx <= '0;
            seq_err <= 1'b0;
        end else if (start) begin
            exp_idx <= '0;
            seq_err <= 1'b0;
        end else if (take_vec) begin
            exp_idx <= exp_idx + N_IN'(1);
            seq_err <= seq_next;
        end
    end
`else
    assign seq_next = 1'b0;
    assign seq_err  = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            coverage        <= '0;
        end else if (start) begin
            state           <= ST_COLLECT;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            coverage        <= '0;
        end else if (take_vec) begin
            coverage  <= cov_next;
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= vec;
            end
            if (complete) begin
                state <= ST_DONE;
                pass  <= (err_next == 5'd0) && !seq_next;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: three instances (N_IN = 3, 4, 2) share one stimulus
// bus, with start/vec_valid steered to the instance under test.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [3:0] vec = '0;
    logic       y_obs = 1'b0;
    int         sel = 0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    logic [15:0] g3 = 16'h00E8;
    logic [15:0] g4 = 16'h8CEF;
    logic [15:0] g2 = 16'h0006;

    logic        busy3, done3, pass3, fev3_v, seq3;
    logic [4:0]  err3;
    logic [2:0]  fev3;
    logic [15:0] cov3;
    logic        busy4, done4, pass4, fev4_v, seq4;
    logic [4:0]  err4;
    logic [3:0]  fev4;
    logic [15:0] cov4;
    logic        busy2, done2, pass2, fev2_v, seq2;
    logic [4:0]  err2;
    logic [1:0]  fev2;
    logic [15:0] cov2;

    truth_table_checker #(.N_IN(3), .GOLDEN(16'h00E8)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 3), .vec_valid(vec_valid && sel == 3),
        .vec(vec[2:0]), .y_obs(y_obs), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_valid(fev3_v), .first_err_vec(fev3), .coverage(cov3),
        .seq_err(seq3));

    truth_table_checker #(.N_IN(4), .GOLDEN(16'h8CEF)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 4), .vec_valid(vec_valid && sel == 4),
        .vec(vec), .y_obs(y_obs), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_err_valid(fev4_v), .first_err_vec(fev4), .coverage(cov4),
        .seq_err(seq4));

    truth_table_checker #(.N_IN(2), .GOLDEN(16'h0006)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .vec_valid(vec_valid && sel == 2),
        .vec(vec[1:0]), .y_obs(y_obs), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_valid(fev2_v), .first_err_vec(fev2), .coverage(cov2),
        .seq_err(seq2));

    typedef struct {
        logic        st;
        logic        vv;
        logic [3:0]  v;
        logic        y;
        logic        busy;
        logic        done;
        logic        pass;
        logic [4:0]  err;
        logic [15:0] cov;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic st, input logic vv, input logic [3:0] v,
                                input logic y, input logic b, input logic d, input logic p,
                                input logic [4:0] e, input logic [15:0] c);
        vec_t r;
        r.st = st; r.vv = vv; r.v = v; r.y = y;
        r.busy = b; r.done = d; r.pass = p; r.err = e; r.cov = c;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the following edge.
    task automatic apply(input int s, input logic st, input logic vv, input logic [3:0] v,
                         input logic y);
        sel = s; start = st; vec_valid = vv; vec = v; y_obs = y;
        @(posedge clk);
        #1;
        start = 1'b0; vec_valid = 1'b0;
    endtask

    initial begin
        // N_IN=3: vec_valid in IDLE, full correct sweep, duplicate wrong row, activity in DONE
        tbl[0]  = mk(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
        tbl[1]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000);
        for (int i = 0; i < 8; i++)
            tbl[2+i] = mk(1'b0, 1'b1, 4'(i), g3[i], i != 7, i == 7, i == 7, 5'd0,
                          16'((1 << (i + 1)) - 1));
        tbl[10] = mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000);
        for (int i = 0; i < 7; i++)
            tbl[11+i] = mk(1'b0, 1'b1, 4'(i), g3[i], 1'b1, 1'b0, 1'b0, 5'd0,
                           16'((1 << (i + 1)) - 1));
        tbl[18] = mk(1'b0, 1'b1, 4'd3, ~g3[3], 1'b1, 1'b0, 1'b0, 5'd0, 16'h007F);
        tbl[19] = mk(1'b0, 1'b1, 4'd7, g3[7], 1'b0, 1'b1, 1'b1, 5'd0, 16'h00FF);
        tbl[20] = mk(1'b0, 1'b1, 4'd0, ~g3[0], 1'b0, 1'b1, 1'b1, 5'd0, 16'h00FF);

        #12;
        check("reset_busy", 32'(busy3), 0);
        check("reset_done", 32'(done3), 0);
        check("reset_pass", 32'(pass3), 0);
        check("reset_cov", 32'(cov3), 0);
        check("reset_err", 32'(err3), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            apply(3, tbl[i].st, tbl[i].vv, tbl[i].v, tbl[i].y);
            check($sformatf("t%0d_busy", i), 32'(busy3), 32'(tbl[i].busy));
            check($sformatf("t%0d_done", i), 32'(done3), 32'(tbl[i].done));
            check($sformatf("t%0d_pass", i), 32'(pass3), 32'(tbl[i].pass));
            check($sformatf("t%0d_err", i), 32'(err3), 32'(tbl[i].err));
            check($sformatf("t%0d_cov", i), 32'(cov3), 32'(tbl[i].cov));
        end

        // N_IN=4: wrong outputs on rows 5 and 12
        apply(4, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int v = 0; v < 16; v++) begin
            apply(4, 1'b0, 1'b1, 4'(v), g4[v] ^ (v == 5 || v == 12));
            if (v == 5) begin
                check("err4_mid_count", 32'(err4), 1);
                check("err4_mid_fev", 32'(fev4), 5);
            end
        end
        check("err4_done", 32'(done4), 1);
        check("err4_busy", 32'(busy4), 0);
        check("err4_count", 32'(err4), 2);
        check("err4_fev", 32'(fev4), 5);
        check("err4_fev_valid", 32'(fev4_v), 1);
        check("err4_pass", 32'(pass4), 0);
        check("err4_cov", 32'(cov4), 32'hFFFF);

        // Restart mid-COLLECT with a same-cycle vector that must be dropped
        apply(4, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int v = 0; v < 5; v++) apply(4, 1'b0, 1'b1, 4'(v), g4[v] ^ (v == 4));
        check("rst4_pre_err", 32'(err4), 1);
        check("rst4_pre_fev", 32'(fev4), 4);
        apply(4, 1'b1, 1'b1, 4'd5, g4[5]);
        check("rst4_cov", 32'(cov4), 0);
        check("rst4_busy", 32'(busy4), 1);
        check("rst4_err", 32'(err4), 0);
        check("rst4_fev_valid", 32'(fev4_v), 0);
        check("rst4_fev", 32'(fev4), 0);
        for (int v = 0; v < 16; v++) begin
            apply(4, 1'b0, 1'b1, 4'(v), g4[v]);
            if (v == 14) check("rst4_not_done", 32'(done4), 0);
        end
        check("rst4_done", 32'(done4), 1);
        check("rst4_pass", 32'(pass4), 1);
        check("rst4_cov_full", 32'(cov4), 32'hFFFF);

        // Asynchronous reset mid-sweep, checked before any clock edge
        apply(3, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int v = 0; v < 4; v++) apply(3, 1'b0, 1'b1, 4'(v), g3[v] ^ (v == 2));
        check("arst_pre_err", 32'(err3), 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy3), 0);
        check("arst_cov", 32'(cov3), 0);
        check("arst_err", 32'(err3), 0);
        check("arst_fev_valid", 32'(fev3_v), 0);
        check("arst_fev", 32'(fev3), 0);
        check("arst_done4", 32'(done4), 0);
        check("arst_pass4", 32'(pass4), 0);
        rst_n = 1'b1;
        #1;

        // Out-of-order sweep 0,2,1,3 on N_IN=2
        apply(2, 1'b1, 1'b0, 4'd0, 1'b0);
        apply(2, 1'b0, 1'b1, 4'd0, g2[0]);
        apply(2, 1'b0, 1'b1, 4'd2, g2[2]);
`ifdef TTC_STRICT_ORDER_EN
        check("ord_seq_early", 32'(seq2), 1);
`else
        check("ord_seq_early", 32'(seq2), 0);
`endif
        apply(2, 1'b0, 1'b1, 4'd1, g2[1]);
        apply(2, 1'b0, 1'b1, 4'd3, g2[3]);
        check("ord_done", 32'(done2), 1);
        check("ord_cov", 32'(cov2), 32'h000F);
        check("ord_err", 32'(err2), 0);
`ifdef TTC_STRICT_ORDER_EN
        check("ord_seq", 32'(seq2), 1);
        check("ord_pass", 32'(pass2), 0);
`else
        check("ord_seq", 32'(seq2), 0);
        check("ord_pass", 32'(pass2), 1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
